// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: core first, then peripherals after a delay.
// Re-asserts all resets on filtered loss of lock or on a soft-reset request.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PERIPH_DELAY       = 256,
    parameter int LOSS_FILTER        = 4,
    parameter int TIMEOUT_CYCLES     = 1048576
) (
    input  logic       i_sys_clk,
    input  logic       i_reset,
    input  logic       i_pll_lock,
    input  logic       i_soft_rst,
    output logic       o_rst_core,
    output logic       o_rst_periph,
    output logic       o_ready,
    output logic       o_lock_timeout,
    output logic [7:0] o_lock_loss_count,
    output logic [1:0] o_state
);

    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int DLY_W    = $clog2(PERIPH_DELAY) + 1;
    localparam int LOSS_W   = $clog2(LOSS_FILTER) + 1;
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DLY_W-1:0]    DLY_LAST    = DLY_W'(PERIPH_DELAY - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        CORE_REL  = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [STABLE_W-1:0] r_stable_cnt;
    logic [DLY_W-1:0]    r_dly_cnt;
    logic [LOSS_W-1:0]   r_loss_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic w_lock_s;
    logic w_loss_hit;
    logic w_restart;

    assign w_lock_s   = r_sync2;
    assign w_loss_hit = !w_lock_s && (r_loss_cnt == LOSS_LAST);
    // Soft reset and lock loss both restart the sequence; only loss is counted.
    assign w_restart  = (r_state != WAIT_LOCK) && (i_soft_rst || w_loss_hit);
    assign o_state    = r_state;

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state           <= WAIT_LOCK;
            r_sync1           <= 1'b0;
            r_sync2           <= 1'b0;
            r_stable_cnt      <= '0;
            r_dly_cnt         <= '0;
            r_loss_cnt        <= '0;
            r_tmo_cnt         <= '0;
            o_rst_core        <= 1'b1;
            o_rst_periph      <= 1'b1;
            o_ready           <= 1'b0;
            o_lock_timeout    <= 1'b0;
            o_lock_loss_count <= 8'd0;
        end else begin
            r_sync1 <= i_pll_lock;
            r_sync2 <= r_sync1;
            if (w_restart) begin
                r_state      <= WAIT_LOCK;
                r_stable_cnt <= '0;
                r_dly_cnt    <= '0;
                r_loss_cnt   <= '0;
                r_tmo_cnt    <= '0;
                o_rst_core   <= 1'b1;
                o_rst_periph <= 1'b1;
                o_ready      <= 1'b0;
                if (!i_soft_rst && (o_lock_loss_count != 8'hFF)) begin
                    o_lock_loss_count <= o_lock_loss_count + 8'd1;
                end
            end else begin
                case (r_state)
                    WAIT_LOCK: begin
                        if (r_tmo_cnt != TMO_MAX) begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                            if (r_tmo_cnt == TMO_LAST) begin
                                o_lock_timeout <= 1'b1;
                            end
                        end
                        if (i_soft_rst || !w_lock_s) begin
                            r_stable_cnt <= '0;
                        end else if (r_stable_cnt == STABLE_LAST) begin
                            r_stable_cnt <= '0;
                            r_tmo_cnt    <= '0;
                            r_state      <= CORE_REL;
                            o_rst_core   <= 1'b0;
                        end else begin
                            r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
                        end
                    end
                    CORE_REL: begin
                        r_loss_cnt <= w_lock_s ? '0 : r_loss_cnt + LOSS_W'(1);
                        if (r_dly_cnt == DLY_LAST) begin
                            r_dly_cnt    <= '0;
                            r_state      <= RUN;
                            o_rst_periph <= 1'b0;
                            o_ready      <= 1'b1;
                        end else begin
                            r_dly_cnt <= r_dly_cnt + DLY_W'(1);
                        end
                    end
                    RUN: begin
                        r_loss_cnt <= w_lock_s ? '0 : r_loss_cnt + LOSS_W'(1);
                    end
                    default: begin
                        r_state      <= WAIT_LOCK;
                        o_rst_core   <= 1'b1;
                        o_rst_periph <= 1'b1;
                        o_ready      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a queue-based scoreboard of
// {rst_core, rst_periph, ready, lock_timeout, lock_loss_count}.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_pll_lock;
  logic       i_soft_rst;
  logic       o_rst_core;
  logic       o_rst_periph;
  logic       o_ready;
  logic       o_lock_timeout;
  logic [7:0] o_lock_loss_count;
  logic [1:0] o_state;

  int n_chk;
  int n_err;
  logic [11:0] exp_q[$];
  logic [7:0] exp_cnt;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(16),
    .PERIPH_DELAY(8),
    .LOSS_FILTER(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_sys_clk(clk),
    .i_reset(i_reset),
    .i_pll_lock(i_pll_lock),
    .i_soft_rst(i_soft_rst),
    .o_rst_core(o_rst_core),
    .o_rst_periph(o_rst_periph),
    .o_ready(o_ready),
    .o_lock_timeout(o_lock_timeout),
    .o_lock_loss_count(o_lock_loss_count),
    .o_state(o_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic core, input logic periph,
                                     input logic rdy, input logic tmo,
                                     input logic [7:0] cnt);
    return {core, periph, rdy, tmo, cnt};
  endfunction

  function automatic logic [11:0] cur_out();
    return {o_rst_core, o_rst_periph, o_ready, o_lock_timeout, o_lock_loss_count};
  endfunction

  // driver tasks: every step ends on a falling edge, where inputs are driven
  // and outputs sampled
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic lock_val);
    i_reset    = 1'b1;
    i_pll_lock = lock_val;
    i_soft_rst = 1'b0;
    tick(2);
    i_reset = 1'b0;
  endtask

  // scoreboard
  task automatic check_out(input string tag);
    logic [11:0] e;
    logic [11:0] o;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    o = cur_out();
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic expect_step(input logic [11:0] e, input int n, input string tag);
    exp_q.push_back(e);
    tick(n);
    check_out(tag);
  endtask

  // which: 0 = rst_core high, 1 = rst_core low, 2 = ready high
  task automatic wait_until(input int which, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if ((which == 0 && o_rst_core === 1'b1) ||
          (which == 1 && o_rst_core === 1'b0) ||
          (which == 2 && o_ready === 1'b1)) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    assert (hit === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed no event expected event within %0d cycles", tag, budget);
    end
  endtask

  // peripherals may never leave reset while the core is still held
  always @(negedge clk) begin
    n_chk++;
    assert (!(o_rst_periph === 1'b0 && o_rst_core !== 1'b0)) else begin
      n_err++;
      $error("FAIL invariant: observed core=%b periph=%b expected core=0 when periph=0",
             o_rst_core, o_rst_periph);
    end
  end

  initial begin
    n_chk      = 0;
    n_err      = 0;
    i_reset    = 1'b1;
    i_pll_lock = 1'b0;
    i_soft_rst = 1'b0;
    @(negedge clk);
    tick(2);
    expect_step(mk(1, 1, 0, 0, 8'd0), 0, "reset_values");

    // clean power-up: lock sampled high at edge 0
    i_reset    = 1'b0;
    i_pll_lock = 1'b1;
    expect_step(mk(1, 1, 0, 0, 8'd0), 17, "t1_core_held_e16");
    expect_step(mk(0, 1, 0, 0, 8'd0), 1, "t1_core_rel_e17");
    expect_step(mk(0, 1, 0, 0, 8'd0), 7, "t1_periph_held_e24");
    expect_step(mk(0, 0, 1, 0, 8'd0), 1, "t1_ready_e25");

    // 3-cycle dropout is filtered
    i_pll_lock = 1'b0;
    tick(3);
    i_pll_lock = 1'b1;
    expect_step(mk(0, 0, 1, 0, 8'd0), 8, "t3_short_dropout");

    // 4-cycle dropout starting at sample edge L
    i_pll_lock = 1'b0;
    tick(4);
    i_pll_lock = 1'b1;
    expect_step(mk(0, 0, 1, 0, 8'd0), 1, "t3_loss_L4");
    expect_step(mk(1, 1, 0, 0, 8'd1), 1, "t3_loss_L5");
    expect_step(mk(1, 1, 0, 0, 8'd1), 15, "t3_reseq_held");
    expect_step(mk(0, 1, 0, 0, 8'd1), 1, "t3_reseq_core");
    expect_step(mk(0, 1, 0, 0, 8'd1), 7, "t3_reseq_periph_held");
    expect_step(mk(0, 0, 1, 0, 8'd1), 1, "t3_reseq_ready");

    // one-cycle soft reset in RUN
    i_soft_rst = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 0, 8'd1));
    tick(1);
    i_soft_rst = 1'b0;
    check_out("t5_soft_assert");
    expect_step(mk(1, 1, 0, 0, 8'd1), 15, "t5_soft_held");
    expect_step(mk(0, 1, 0, 0, 8'd1), 1, "t5_soft_core");
    expect_step(mk(0, 1, 0, 0, 8'd1), 7, "t5_soft_periph_held");
    expect_step(mk(0, 0, 1, 0, 8'd1), 1, "t5_soft_ready");

    // soft reset coincident with the loss threshold is not counted
    i_pll_lock = 1'b0;
    tick(5);
    i_soft_rst = 1'b1;
    i_pll_lock = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 0, 8'd1));
    tick(1);
    check_out("t5_soft_beats_loss");
    // soft reset held in WAIT_LOCK keeps the stable count at zero
    expect_step(mk(1, 1, 0, 0, 8'd1), 20, "t5_soft_hold_wait");
    i_soft_rst = 1'b0;
    expect_step(mk(1, 1, 0, 0, 8'd1), 15, "t5_hold_release_held");
    expect_step(mk(0, 1, 0, 0, 8'd1), 1, "t5_hold_release_core");
    expect_step(mk(0, 0, 1, 0, 8'd1), 8, "t5_hold_release_ready");

    // lock chatter: high 10, low 1, then high from sample edge 11
    do_reset(1'b1);
    tick(10);
    i_pll_lock = 1'b0;
    tick(1);
    i_pll_lock = 1'b1;
    expect_step(mk(1, 1, 0, 0, 8'd0), 17, "t2_chatter_held");
    expect_step(mk(0, 1, 0, 0, 8'd0), 1, "t2_chatter_core");
    expect_step(mk(0, 0, 1, 0, 8'd0), 8, "t2_chatter_ready");

    // lock acquisition timeout
    do_reset(1'b0);
    expect_step(mk(1, 1, 0, 0, 8'd0), 99, "t4_tmo_before");
    expect_step(mk(1, 1, 0, 1, 8'd0), 1, "t4_tmo_set");
    expect_step(mk(1, 1, 0, 1, 8'd0), 50, "t4_tmo_sticky_wait");
    i_pll_lock = 1'b1;
    expect_step(mk(1, 1, 0, 1, 8'd0), 17, "t4_late_lock_held");
    expect_step(mk(0, 1, 0, 1, 8'd0), 1, "t4_late_lock_core");
    expect_step(mk(0, 0, 1, 1, 8'd0), 8, "t4_late_lock_ready");

    // saturation of the loss counter
    exp_cnt = 8'd0;
    for (int i = 0; i < 260; i++) begin
      i_pll_lock = 1'b0;
      wait_until(0, 20, "t6_loss_wait");
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      exp_q.push_back(mk(1, 1, 0, 1, exp_cnt));
      check_out("t6_loss_count");
      i_pll_lock = 1'b1;
      wait_until(2, 60, "t6_ready_wait");
    end

    // asynchronous reset while in CORE_REL
    i_pll_lock = 1'b0;
    wait_until(0, 20, "t6_last_loss_wait");
    exp_q.push_back(mk(1, 1, 0, 1, 8'hFF));
    check_out("t6_count_saturated");
    i_pll_lock = 1'b1;
    wait_until(1, 60, "t6_core_rel_wait");
    tick(2);
    i_reset = 1'b1;
    #1;
    exp_q.push_back(mk(1, 1, 0, 0, 8'd0));
    check_out("t6_async_reset");
    tick(2);
    i_reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits downstream of the PLL clock block and consumes its 66.0 MHz system clock and the PLL LOCK output. It produces the staged synchronous resets used by the rest of the design: core logic is released first, then peripherals (UART, SPI, USB3 FIFO).
It watches for loss of lock and re-asserts all resets when lock is lost. It also reports lock-acquisition timeout and counts lock-loss events for debug.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive cycles synchronised lock must stay high before core reset is released (>=2)
PERIPH_DELAY, 256, cycles between core reset release and peripheral reset release (>=1)
LOSS_FILTER, 4, consecutive cycles synchronised lock must stay low to count as lock loss (>=1)
TIMEOUT_CYCLES, 1048576, cycles allowed in WAIT_LOCK before o_lock_timeout is raised (>=1)

Ports:
i_sys_clk  in  1  system clock (buffered PLL output)
i_reset  in  1  asynchronous, active-high reset
i_pll_lock  in  1  PLL LOCK, asynchronous to i_sys_clk
i_soft_rst  in  1  synchronous request to rerun the reset sequence
o_rst_core  out  1  active-high core reset
o_rst_periph  out  1  active-high peripheral reset
o_ready  out  1  high while sequence complete (RUN)
o_lock_timeout  out  1  sticky: lock not acquired within TIMEOUT_CYCLES
o_lock_loss_count  out  8  saturating count of lock-loss events

Behaviour:
Interface and reset:
- One clock, i_sys_clk. Reset i_reset is asynchronous and active-high.
- On reset: o_rst_core=1, o_rst_periph=1, o_ready=0, o_lock_timeout=0, o_lock_loss_count=0, synchroniser flops=0, all counters=0, state=WAIT_LOCK.
- All outputs are registered.

Lock synchroniser:
- i_pll_lock passes through a 2-flop synchroniser to give lock_s.
- Edge numbering: the first edge that samples i_pll_lock high is edge 0; lock_s is high after edge 1.

Counter widths:
- Each counter is sized with $clog2 of its limit plus 1.
- No counter may wrap: every counter saturates or stops at its terminal value.

WAIT_LOCK (o_rst_core=1, o_rst_periph=1, o_ready=0):
- stable_cnt increments on every edge where lock_s=1. It clears on any edge where lock_s=0.
- When stable_cnt reaches LOCK_STABLE_CYCLES, go to CORE_REL.
- Resulting timing: o_rst_core goes low after edge LOCK_STABLE_CYCLES+1, for a steady lock.
- tmo_cnt counts every cycle spent in WAIT_LOCK. It is not cleared by lock glitches.
- At TIMEOUT_CYCLES, tmo_cnt sets o_lock_timeout and stops counting.
- o_lock_timeout is cleared only by i_reset. The FSM keeps waiting after a timeout.
- tmo_cnt clears on exit from WAIT_LOCK.

CORE_REL (o_rst_core=0, o_rst_periph=1, o_ready=0):
- dly_cnt counts PERIPH_DELAY edges, then go to RUN.
- o_rst_periph goes low and o_ready goes high on the same edge.
- Timing: after edge LOCK_STABLE_CYCLES+1+PERIPH_DELAY.

RUN (all resets low, o_ready=1):
- loss_cnt counts consecutive edges with lock_s=0. It clears when lock_s=1.
- When loss_cnt reaches LOSS_FILTER:
  - All resets assert and o_ready drops, registered on that edge.
  - o_lock_loss_count increments, saturating at 255.
  - Go to WAIT_LOCK.
- Lock low at sample edge L therefore asserts resets after edge L+1+LOSS_FILTER.
- Lock-low glitches shorter than LOSS_FILTER cycles have no effect.

Lock loss in CORE_REL:
- Same LOSS_FILTER rule as RUN.
- Returns to WAIT_LOCK and re-asserts o_rst_core.
- Counts as a lock-loss event.

Soft reset:
- i_soft_rst=1 in CORE_REL or RUN: next edge asserts all resets, drops o_ready, goes to WAIT_LOCK.
- stable_cnt, dly_cnt and loss_cnt are cleared. o_lock_loss_count is not incremented.
- i_soft_rst=1 in WAIT_LOCK holds stable_cnt at 0. tmo_cnt keeps counting.
- Simultaneous soft reset and lock-loss threshold: soft reset wins, so the loss count is not incremented.

Reset mid-operation:
- i_reset asserting in any state immediately forces all reset values. This includes clearing the sticky flag and the loss count.

Invariant:
- o_rst_periph=0 implies o_rst_core=0, in every cycle.

Test Plan:
All scenarios use LOCK_STABLE_CYCLES=16, PERIPH_DELAY=8, LOSS_FILTER=4, TIMEOUT_CYCLES=100.
1. Clean power-up: deassert i_reset, raise i_pll_lock before edge 0 and hold it -> o_rst_core falls after edge 17; o_rst_periph falls and o_ready rises after edge 25; o_lock_timeout stays 0.
2. Lock chatter: lock high 10 cycles, low 1 cycle, then high -> stable_cnt restarts; o_rst_core falls 17 edges after the final rising sample.
3. Loss filtering in RUN: 3-cycle lock dropout -> no change, count=0. Then a 4-cycle dropout starting at sample edge L -> all resets assert after edge L+5, count=1, FSM resequences once lock returns.
4. Timeout: keep lock low 150 cycles -> o_lock_timeout=1 after 100 cycles in WAIT_LOCK. Then raise lock -> normal sequence completes and o_lock_timeout stays 1.
5. Soft reset: pulse i_soft_rst for 1 cycle in RUN -> all resets high next edge and o_ready=0; resequence completes 16+8 cycles after re-entry (plus the stable-count edge); count unchanged.
6. Saturation and async reset: force 260 lock losses -> count stays at 255. Assert i_reset mid-CORE_REL -> all outputs return to reset values without waiting for a clock edge.
